seg_display_scanner: RTL and testbench



---
 rtl/seg_display_scanner.sv | 127 ++++++++++++
 tb/tb_seg_display_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Four-digit common-anode seven-segment scanner.
// Latches a 16-bit value and cycles its nibbles out to a downstream
// hex-to-seven-segment decoder, driving the matching active-low anode.
// All outputs are registered from next-state values so anode, nibble and
// digit index always agree within a cycle.
module seg_display_scanner #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  hex_out,
  output logic [3:0]  an,
  output logic        digit_tick
);

  localparam int unsigned     PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_e;

  logic [15:0]   value_q, value_d;
  logic [PW-1:0] presc_q, presc_d;
  digit_e        digit_q, digit_d;
  logic          run_q,   run_d;
  logic [3:0]    hex_q,   hex_d;
  logic [3:0]    an_q,    an_d;
  logic          tick_q,  tick_d;
  logic          blank_d;

  // Next-state: value latch, prescaler, digit sequencing and registered outputs.
  // run_q marks that scanning has started; the first enabled edge after reset
  // or disable parks on D0 with the prescaler at 0 so D0 gets a full slot.
  always_comb begin
    value_d = load ? value_in : value_q;
    presc_d = presc_q;
    digit_d = digit_q;
    run_d   = run_q;
    tick_d  = 1'b0;
    hex_d   = 4'h0;
    an_d    = 4'b1111;
    blank_d = 1'b0;

    if (!enable) begin
      presc_d = '0;
      digit_d = D0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      presc_d = '0;
      digit_d = D0;
      run_d   = 1'b1;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
      unique case (digit_q)
        D0:      digit_d = D1;
        D1:      digit_d = D2;
        D2:      digit_d = D3;
        default: digit_d = D0;
      endcase
    end else begin
      presc_d = presc_q + 1'b1;
    end

    unique case (digit_d)
      D0: begin
        hex_d   = value_d[3:0];
        blank_d = 1'b0;
      end
      D1: begin
        hex_d   = value_d[7:4];
        blank_d = (value_d[15:4] == 12'h000);
      end
      D2: begin
        hex_d   = value_d[11:8];
        blank_d = (value_d[15:8] == 8'h00);
      end
      default: begin
        hex_d   = value_d[15:12];
        blank_d = (value_d[15:12] == 4'h0);
      end
    endcase

    if (enable && !(BLANK_LEADING && blank_d)) begin
      unique case (digit_d)
        D0:      an_d = 4'b1110;
        D1:      an_d = 4'b1101;
        D2:      an_d = 4'b1011;
        default: an_d = 4'b0111;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      presc_q <= '0;
      digit_q <= D0;
      run_q   <= 1'b0;
      hex_q   <= 4'h0;
      an_q    <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      run_q   <= run_d;
      hex_q   <= hex_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign hex_out    = hex_q;
  assign an         = an_q;
  assign digit_tick = tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Testbench for seg_display_scanner: three configurations share one stimulus
// stream and are compared each cycle against a time-based reference model.
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        enable;

  logic [3:0]  an_w  [3];
  logic [3:0]  hex_w [3];
  logic        tk_w  [3];

  int total = 0;
  int bad   = 0;

  // Reference model: shared latched value, and per instance the number of
  // enabled edges since scanning (re)started (-1 when dark/reset).
  logic [15:0] mv;
  int          mt [3];
  int          mn [3] = '{4, 4, 1};
  bit          mb [3] = '{1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  seg_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_a (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .enable(enable),
    .hex_out(hex_w[0]), .an(an_w[0]), .digit_tick(tk_w[0]));

  seg_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_b (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .enable(enable),
    .hex_out(hex_w[1]), .an(an_w[1]), .digit_tick(tk_w[1]));

  seg_display_scanner #(.REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_c (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .enable(enable),
    .hex_out(hex_w[2]), .an(an_w[2]), .digit_tick(tk_w[2]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int k, output logic [3:0] e_an,
                            output logic [3:0] e_hex, output logic e_tk);
    int          d;
    logic [15:0] upper;
    if (mt[k] < 0) begin
      e_an  = 4'b1111;
      e_hex = mv[3:0];
      e_tk  = 1'b0;
    end else begin
      d     = (mt[k] / mn[k]) % 4;
      upper = mv >> (4 * d);
      e_hex = upper[3:0];
      e_tk  = (mt[k] > 0) && (mt[k] % mn[k] == 0);
      if (mb[k] && d >= 1 && upper == 16'h0000) e_an = 4'b1111;
      else                                      e_an = ~(4'b0001 << d);
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [15:0] v, input bit e);
    logic [3:0] e_an, e_hex;
    logic       e_tk;
    rst = r; load = l; value_in = v; enable = e;
    @(posedge clk);
    if (r) begin
      mv = 16'h0000;
      for (int k = 0; k < 3; k++) mt[k] = -1;
    end else begin
      if (l) mv = v;
      for (int k = 0; k < 3; k++) mt[k] = e ? ((mt[k] < 0) ? 0 : mt[k] + 1) : -1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      expect_out(k, e_an, e_hex, e_tk);
      chk($sformatf("an[%0d]", k), an_w[k], e_an);
      chk($sformatf("hex[%0d]", k), hex_w[k], e_hex);
      chk($sformatf("tick[%0d]", k), {3'b000, tk_w[k]}, {3'b000, e_tk});
      total++;
      assert ($countones(~an_w[k]) <= 1) else begin
        bad++;
        $error("FAIL onehot[%0d] observed=%b expected=at most one low", k, an_w[k]);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  initial begin
    logic [15:0] rv;
    int          guard;
    mv = 16'h0000;
    for (int k = 0; k < 3; k++) mt[k] = -1;

    // Reset held with load/enable active must win.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    chk("rst_an", an_w[0], 4'b1111);
    chk("rst_hex", hex_w[0], 4'h0);
    run(6);

    // Full pattern without blanking.
    step(1'b0, 1'b1, 16'hA3F0, 1'b1);
    run(20);

    // Leading-zero blanking cases.
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    run(16);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    run(16);
    step(1'b0, 1'b1, 16'h1000, 1'b1);
    run(16);

    // Load coincident with the D0->D1 advance.
    step(1'b0, 1'b1, 16'hABCD, 1'b1);
    guard = 0;
    while ((mt[0] % 16) != 3 && guard < 64) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      guard++;
    end
    chk("align_wrap", (guard < 64) ? 4'h1 : 4'h0, 4'h1);
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("ld_adv_an", an_w[0], 4'b1101);
    chk("ld_adv_hex", hex_w[0], 4'h3);

    // Drop enable during D2, hold dark, then re-enable.
    guard = 0;
    while (((mt[0] / 4) % 4) != 2 && guard < 64) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      guard++;
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("dis_an", an_w[0], 4'b1111);
    chk("dis_tick", {3'b000, tk_w[0]}, 4'h0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      chk("reen_d0", an_w[0], 4'b1110);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("reen_d1", an_w[0], 4'b1101);

    // Fast scan, then mid-sequence reset.
    step(1'b0, 1'b1, 16'h4321, 1'b1);
    run(8);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("mid_rst_an", an_w[2], 4'b1111);
    run(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, rv,
           $urandom_range(0, 9) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
